// File: rtl/wam_pkg.sv
// Shared constants, FSM state type and score helper for the whack-a-mole
// player side.
package wam_pkg;

  localparam int N_HOLES         = 9;
  localparam int SCORE_W         = 7;
  localparam int LIVES_W         = 2;
  localparam int DEBOUNCE_CYCLES = 500_000;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    WAIT_CLEAR,
    GAME_OVER
  } state_t;

  function automatic logic [SCORE_W-1:0] sat_add(
    input logic [SCORE_W-1:0] a,
    input logic [1:0]         inc,
    input int                 max
  );
    int s;
    s = int'(a) + int'(inc);
    return (s > max) ? SCORE_W'(max) : SCORE_W'(s);
  endfunction

endpackage

// File: rtl/whack_detector_if.sv
// Mole handshake between the light controller (master) and the
// whack detector (slave).
interface whack_detector_if #(
  parameter int N = wam_pkg::N_HOLES
);
  import wam_pkg::*;

  logic [N-1:0] mole_mask;
  logic         mole_valid;
  logic         clear_mole;

  modport master (
    output mole_mask,
    output mole_valid,
    input  clear_mole
  );

  modport slave (
    input  mole_mask,
    input  mole_valid,
    output clear_mole
  );

endinterface

// File: rtl/input_debouncer.sv
// One switch bit: 2-FF sync, stable-count debounce, registered
// rising-edge press pulse.
module input_debouncer #(
  parameter int DEBOUNCE_CYCLES = wam_pkg::DEBOUNCE_CYCLES
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic raw,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          s1;
  logic          s2;
  logic          stable;
  logic          stable_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      cnt      <= '0;
      press    <= 1'b0;
    end else begin
      s1       <= raw;
      s2       <= s1;
      stable_d <= stable;
      press    <= stable & ~stable_d;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/whack_detector.sv
// Judges player presses against the lit mole; keeps score and lives.
// Define COMBO_BONUS_EN for the streak bonus (+2 from the 4th hit on).
module whack_detector #(
  parameter int N_HOLES         = wam_pkg::N_HOLES,
  parameter int DEBOUNCE_CYCLES = wam_pkg::DEBOUNCE_CYCLES,
  parameter int START_LIVES     = 3,
  parameter int SCORE_MAX       = 99
) (
  input  logic                        CLOCK_50,
  input  logic                        reset,
  input  logic [N_HOLES-1:0]          sw,
  whack_detector_if.slave             bus,
  output logic                        hit,
  output logic                        miss,
  output logic [wam_pkg::SCORE_W-1:0] score,
  output logic [wam_pkg::LIVES_W-1:0] lives,
  output logic                        game_over
);

  import wam_pkg::*;

  logic [N_HOLES-1:0] press;
  logic [N_HOLES-1:0] target;
  logic [N_HOLES-1:0] target_n;
  state_t             state;
  state_t             state_n;
  logic [SCORE_W-1:0] score_n;
  logic [LIVES_W-1:0] lives_n;
  logic               hit_n;
  logic               miss_n;
  logic               clr_n;
  logic               in_t;
  logic               out_t;
  logic [1:0]         inc;
`ifdef COMBO_BONUS_EN
  logic [2:0]         streak;
  logic [2:0]         streak_n;
`endif

  for (genvar i = 0; i < N_HOLES; i++) begin : g_db
    input_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .CLOCK_50(CLOCK_50),
      .reset   (reset),
      .raw     (sw[i]),
      .press   (press[i])
    );
  end

  assign in_t      = |(press & target);
  assign out_t     = |(press & ~target);
  assign game_over = (state == GAME_OVER);

  always_comb begin
    state_n  = state;
    target_n = target;
    score_n  = score;
    lives_n  = lives;
    hit_n    = 1'b0;
    miss_n   = 1'b0;
    clr_n    = 1'b0;
`ifdef COMBO_BONUS_EN
    streak_n = streak;
    // this hit makes the streak 4+ when it already stands at 3+
    inc      = (streak >= 3'd3) ? 2'd2 : 2'd1;
`else
    inc      = 2'd1;
`endif
    unique case (state)
      IDLE: begin
        if (bus.mole_valid && |bus.mole_mask) begin
          target_n = bus.mole_mask;
          state_n  = ARMED;
        end
      end
      ARMED: begin
        if (in_t && !out_t) begin
          hit_n   = 1'b1;
          clr_n   = 1'b1;
          score_n = sat_add(score, inc, SCORE_MAX);
          state_n = WAIT_CLEAR;
`ifdef COMBO_BONUS_EN
          streak_n = (streak == 3'd7) ? streak : streak + 3'd1;
`endif
        end else if (out_t || !bus.mole_valid) begin
          miss_n  = 1'b1;
          lives_n = (lives != '0) ? lives - 1'b1 : lives;
`ifdef COMBO_BONUS_EN
          streak_n = '0;
`endif
          if (lives_n == '0) state_n = GAME_OVER;
          else if (out_t)    state_n = WAIT_CLEAR;
          else               state_n = IDLE;
        end
      end
      WAIT_CLEAR: begin
        if (!bus.mole_valid) state_n = IDLE;
      end
      GAME_OVER: ;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      target         <= '0;
      score          <= '0;
      lives          <= LIVES_W'(START_LIVES);
      hit            <= 1'b0;
      miss           <= 1'b0;
      bus.clear_mole <= 1'b0;
    end else begin
      state          <= state_n;
      target         <= target_n;
      score          <= score_n;
      lives          <= lives_n;
      hit            <= hit_n;
      miss           <= miss_n;
      bus.clear_mole <= clr_n;
    end
  end

`ifdef COMBO_BONUS_EN
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) streak <= '0;
    else        streak <= streak_n;
  end
`endif

endmodule

// File: tb/tb_whack_detector.sv
// Directed bench for whack_detector with a 4-cycle debounce.
// Table of mole rounds plus hand sequences for timing corners.
module tb_whack_detector;

  localparam int D = 4;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b0;
  logic [8:0] sw       = '0;
  logic       hit;
  logic       miss;
  logic       game_over;
  logic [6:0] score;
  logic [1:0] lives;

  whack_detector_if bus ();

  whack_detector #(
    .N_HOLES        (9),
    .DEBOUNCE_CYCLES(D),
    .START_LIVES    (3),
    .SCORE_MAX      (99)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .sw       (sw),
    .bus      (bus),
    .hit      (hit),
    .miss     (miss),
    .score    (score),
    .lives    (lives),
    .game_over(game_over)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int nchk = 0;
  int nerr = 0;
  int hit_cnt = 0;
  int miss_cnt = 0;
  int clr_cnt = 0;

  always @(negedge CLOCK_50) begin
    if (hit)            hit_cnt++;
    if (miss)           miss_cnt++;
    if (bus.clear_mole) clr_cnt++;
  end

  typedef struct {
    string      name;
    logic [8:0] mask;
    logic [8:0] prs;
    logic [8:0] extra;
    int         dh;
    int         dm;
    int         sc;
    int         lv;
  } vec_t;

  vec_t tbl[4];

  function automatic vec_t mk(string n, logic [8:0] m, logic [8:0] p,
                              logic [8:0] e, int dh, int dm,
                              int sc, int lv);
    vec_t v;
    v.name = n; v.mask = m; v.prs = p; v.extra = e;
    v.dh = dh; v.dm = dm; v.sc = sc; v.lv = lv;
    return v;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic hold(input logic [8:0] b);
    sw = b;
    cyc(D + 6);
    sw = '0;
    cyc(D + 6);
  endtask

  task automatic round(input logic [8:0] m, input logic [8:0] p,
                       input logic [8:0] e);
    bus.mole_mask  = m;
    bus.mole_valid = 1'b1;
    cyc(2);
    if (p != '0) hold(p);
    if (e != '0) hold(e);
    bus.mole_valid = 1'b0;
    cyc(3);
  endtask

  int h0, m0, c0, lat, clr_at_hit;
  int exp4[4];

  initial begin
    tbl[0] = mk("wait_clear_press", 9'h010, 9'h001, 9'h010, 0, 1, 1, 2);
    tbl[1] = mk("hit_wide_target",  9'h0F0, 9'h020, 9'h000, 1, 0, 2, 2);
    tbl[2] = mk("mixed_press",      9'h010, 9'h030, 9'h000, 0, 1, 2, 1);
    tbl[3] = mk("two_in_target",    9'h101, 9'h101, 9'h000, 1, 0, 3, 1);
`ifdef COMBO_BONUS_EN
    exp4 = '{1, 2, 3, 5};
`else
    exp4 = '{1, 2, 3, 4};
`endif

    bus.mole_mask  = '0;
    bus.mole_valid = 1'b0;
    cyc(3);
    reset = 1'b1;
    cyc(2);
    chk("reset_score", int'(score), 0);
    chk("reset_lives", int'(lives), 3);
    chk("reset_game_over", int'(game_over), 0);
    chk("reset_pulses", hit_cnt + miss_cnt + clr_cnt, 0);

    // 3-cycle glitch while armed must not be accepted
    bus.mole_mask  = 9'h004;
    bus.mole_valid = 1'b1;
    cyc(2);
    sw[2] = 1'b1;
    cyc(3);
    sw[2] = 1'b0;
    cyc(12);
    chk("glitch_judged", hit_cnt + miss_cnt, 0);

    h0 = hit_cnt; m0 = miss_cnt; c0 = clr_cnt;
    lat = -1; clr_at_hit = 0;
    sw[2] = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      cyc(1);
      if (hit && lat < 0) begin
        lat = k;
        clr_at_hit = int'(bus.clear_mole);
      end
    end
    chk("hit_latency", lat, D + 4);
    chk("clear_with_hit", clr_at_hit, 1);
    sw = '0;
    cyc(D + 6);
    bus.mole_valid = 1'b0;
    cyc(3);
    chk("first_hit_count", hit_cnt - h0, 1);
    chk("first_clear_count", clr_cnt - c0, 1);
    chk("first_miss_count", miss_cnt - m0, 0);
    chk("first_score", int'(score), 1);
    chk("first_lives", int'(lives), 3);

    for (int i = 0; i < 4; i++) begin
      h0 = hit_cnt; m0 = miss_cnt; c0 = clr_cnt;
      round(tbl[i].mask, tbl[i].prs, tbl[i].extra);
      chk({tbl[i].name, "_hits"},   hit_cnt - h0,  tbl[i].dh);
      chk({tbl[i].name, "_misses"}, miss_cnt - m0, tbl[i].dm);
      chk({tbl[i].name, "_clears"}, clr_cnt - c0,  tbl[i].dh);
      chk({tbl[i].name, "_score"},  int'(score),   tbl[i].sc);
      chk({tbl[i].name, "_lives"},  int'(lives),   tbl[i].lv);
    end

    // timeout on the last life
    m0 = miss_cnt;
    round(9'h008, 9'h000, 9'h000);
    chk("timeout_miss", miss_cnt - m0, 1);
    chk("timeout_lives", int'(lives), 0);
    chk("timeout_game_over", int'(game_over), 1);

    h0 = hit_cnt; m0 = miss_cnt;
    round(9'h008, 9'h008, 9'h001);
    round(9'h002, 9'h000, 9'h000);
    chk("over_pulses", (hit_cnt - h0) + (miss_cnt - m0), 0);
    chk("over_score", int'(score), 3);
    chk("over_lives", int'(lives), 0);
    chk("over_flag", int'(game_over), 1);

    // reset in mid-debounce
    bus.mole_mask  = 9'h002;
    bus.mole_valid = 1'b1;
    sw = 9'h002;
    cyc(3);
    h0 = hit_cnt; m0 = miss_cnt; c0 = clr_cnt;
    reset = 1'b0;
    sw = '0;
    bus.mole_valid = 1'b0;
    cyc(2);
    reset = 1'b1;
    cyc(D + 8);
    chk("rst_pulses", (hit_cnt - h0) + (miss_cnt - m0) + (clr_cnt - c0), 0);
    chk("rst_lives", int'(lives), 3);
    chk("rst_score", int'(score), 0);
    chk("rst_game_over", int'(game_over), 0);

    // press event lands in the cycle mole_valid drops
    h0 = hit_cnt; m0 = miss_cnt;
    bus.mole_mask  = 9'h010;
    bus.mole_valid = 1'b1;
    cyc(2);
    sw[4] = 1'b1;
    cyc(D + 3);
    bus.mole_valid = 1'b0;
    cyc(3);
    sw = '0;
    cyc(D + 6);
    chk("race_hit", hit_cnt - h0, 1);
    chk("race_miss", miss_cnt - m0, 0);
    chk("race_score", int'(score), 1);

    reset = 1'b0;
    cyc(2);
    reset = 1'b1;
    cyc(2);
    h0 = hit_cnt;
    for (int n = 1; n <= 100; n++) begin
      round(9'h001, 9'h001, 9'h000);
      if (n <= 4) chk($sformatf("streak_score_%0d", n), int'(score), exp4[n-1]);
    end
    chk("sat_hits", hit_cnt - h0, 100);
    chk("sat_score", int'(score), 99);
    chk("sat_lives", int'(lives), 3);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/whack_detector.md
Name: whack_detector

Overview:
- Player-side counterpart to the mole light controller: takes the currently lit mole pattern and the player's switch inputs, and judges each mole as a hit or a miss.
- Synchronizes and debounces the switches, then converts them to one-cycle press events.
- Keeps score and lives, and returns a clear_mole pulse to the light controller on each hit.
- Sits between the board switches and the light/flick logic in the top-level game.

Parameters:
- N_HOLES, 9, number of mole positions (LEDR[8:0] / SW[8:0]).
- DEBOUNCE_CYCLES, 500_000, consecutive stable cycles required before a switch change is accepted (10 ms at 50 MHz).
- START_LIVES, 3, lives loaded at reset (1..3).
- SCORE_MAX, 99, saturation value of score.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low reset.
- sw  in  N_HOLES  raw player switches, asynchronous to CLOCK_50.
- mole_mask  in  N_HOLES  lit mole pattern from the light controller.
- mole_valid  in  1  high while a mole is lit.
- clear_mole  out  1  one-cycle pulse telling the light controller to extinguish the mole.
- hit  out  1  one-cycle pulse per judged hit.
- miss  out  1  one-cycle pulse per judged miss.
- score  out  7  binary score, 0..SCORE_MAX.
- lives  out  2  remaining lives.
- game_over  out  1  high once lives reach 0.

Behaviour:
- Reset: all outputs 0 except lives=START_LIVES. FSM goes to IDLE. Sync flops, debounced state and debounce counters are cleared.
- Input path, per bit:
  - 2-FF synchronizer feeds a debounce counter.
  - Counter resets whenever the synced value equals the stable value; otherwise it increments.
  - At DEBOUNCE_CYCLES-1 the stable value takes the synced value and the counter clears.
  - press[i] = one-cycle pulse on a stable 0->1 transition. Falling transitions do not generate presses.
  - Latency from a clean sw edge to the press pulse is DEBOUNCE_CYCLES+3 cycles.
- FSM states: IDLE, ARMED, WAIT_CLEAR, GAME_OVER.
- IDLE:
  - On mole_valid=1 with a nonzero mole_mask: latch target<=mole_mask and go to ARMED.
  - mole_valid=1 with a zero mask is ignored.
  - Presses are ignored.
- ARMED, checked in priority order each cycle:
  1. Any press bit inside target and no press outside target: hit. score+1 (saturating at SCORE_MAX), clear_mole=1, go to WAIT_CLEAR.
  2. Any press outside target, including a mixed press: one miss regardless of how many bits are pressed. lives-1, go to WAIT_CLEAR.
  3. mole_valid=0 (timeout): miss, lives-1, go to IDLE.
- Simultaneous target press and mole_valid fall: hit wins.
- hit, miss and clear_mole are registered, asserted in the cycle after the judging cycle, and last exactly one cycle.
- WAIT_CLEAR: presses are ignored. Return to IDLE when mole_valid=0.
- A miss that brings lives to 0 moves to GAME_OVER instead, and the miss pulse still fires.
- GAME_OVER: game_over=1; score and lives are frozen; presses and mole_valid are ignored. Only reset exits.
- lives never underflows. score never wraps.
- Reset asserted mid-debounce or in mid-judgment aborts everything immediately, and no pulse is emitted.

Optional Feature:
- COMBO_BONUS_EN defined:
  - A 3-bit streak counter increments on each hit and clears on each miss.
  - A hit that brings the streak to 4 or more adds 2 instead of 1, still saturating at SCORE_MAX.
  - Streak is cleared at reset.
- Not defined: no streak logic; every hit adds 1.

Decomposition:
- Shared package wam_pkg:
  - N_HOLES, SCORE_W=7, LIVES_W=2.
  - Default DEBOUNCE_CYCLES.
  - FSM state typedef (IDLE, ARMED, WAIT_CLEAR, GAME_OVER).
- Sub-module input_debouncer: one bit of synchronizer plus debounce counter plus rising-edge press output, instantiated N_HOLES times via generate.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset release -> score=0, lives=3, game_over=0, all pulses 0. Toggle sw[2] with 3-cycle glitches -> no press and no judgment.
- mole_valid=1, mole_mask=9'b000000100; sw[2] held rising -> hit and clear_mole pulse once, at DEBOUNCE_CYCLES+4 cycles after the edge; score=1, lives=3.
- mole_mask=9'b000010000; press sw[0] -> miss once, lives=2, state WAIT_CLEAR. A further press before mole_valid falls -> no effect.
- mole_valid falls with no press -> miss, lives decrements. Repeat until lives=0 -> game_over=1. Later presses and moles leave score and lives unchanged. Reset -> lives=3.
- Target press event in the same cycle mole_valid drops -> hit (not miss). sw[4] and sw[5] both pressed in the same cycle with target 4 -> single miss.
- 100 consecutive hits -> score saturates at 99. With COMBO_BONUS_EN: hits 1..4 -> score 1, 2, 3, 5.
